async_fifo_stream_reader: RTL and testbench
===========================================

Name: async_fifo_stream_reader

Overview:
- Read-side consumer for async_fifo: sits in the rclk domain, pops words through the FIFO read port (rempty/rinc/rdata) and presents them on a valid/ready stream.
- Groups words into fixed-length packets, with a last flag on the final word of each packet.
- A 2-entry output buffer gives full throughput with no combinational path from m_ready to rinc.

Parameters:
- DATA_SIZE, 32, width of rdata and m_data; must match async_fifo DATA_SIZE.
- BURST_LEN, 16, words per packet; minimum 2.
- CNT_SIZE, 16, width of the pkt_cnt status counter.

Ports:
- rclk  in  1  read-domain clock.
- rrst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; allows new packets to start.
- rempty  in  1  FIFO empty flag.
- rinc  out  1  FIFO pop strobe.
- rdata  in  DATA_SIZE  FIFO head word; valid whenever rempty=0 (FWFT).
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_SIZE  output word.
- m_last  out  1  final word of packet.
- busy  out  1  state != IDLE or buffer occupancy != 0.
- pkt_cnt  out  CNT_SIZE  completed packets (last word accepted).

Behaviour:
- Reset: all of the following, asynchronously on rrst_n=0.
  - Outputs: rinc=0, m_valid=0, m_data=0, m_last=0, busy=0, pkt_cnt=0.
  - Internal: occupancy=0, beat=0, state=IDLE.
- Buffer: 2 entries of {data,last}, occupancy occ in 0..2.
  - m_valid = (occ!=0).
  - The head entry drives m_data/m_last.
  - Transfer occurs when m_valid & m_ready.
- Pop rule: rinc = fetch_ok & !rempty & (occ<2). rinc is combinational from registered state and rempty only.
  - fetch_ok=1 in RUN and FINISH; 0 in IDLE.
- On a pop: rdata is written into the buffer with last=(beat==BURST_LEN-1).
  - beat increments, and wraps to 0 after BURST_LEN-1.
- Same-cycle push and transfer: occ unchanged; the pushed word is ordered after the current head.
- FSM transitions:
  - IDLE -> RUN when enable=1 (beat is 0 here).
  - RUN -> FINISH when enable=0 and beat!=0, i.e. mid-packet.
  - RUN -> IDLE when enable=0 and beat==0.
  - FINISH: keeps popping until the pop with last=1, then -> IDLE.
  - FINISH never returns to RUN directly, even if enable re-asserts.
- Packet integrity: a packet is never truncated. If the FIFO runs empty mid-packet, the block waits indefinitely (rinc=0) until data arrives.
- Buffered words are still delivered after entering IDLE; busy stays 1 until occ==0.
- pkt_cnt increments on a transfer with m_last=1 and wraps modulo 2^CNT_SIZE.
- m_data/m_last hold stable while m_valid=1 and m_ready=0.
- Latency: rempty falling -> rinc same cycle (when in RUN and occ<2) -> m_valid next cycle.
- Throughput: sustained 1 word/cycle while !rempty and m_ready=1.
- Reset mid-packet: buffer contents are discarded and beat is cleared; FIFO-side recovery belongs to async_fifo's rrst_n.

Optional Feature:
- FIFO_RD_PARITY_EN defined: adds output port m_parity (1 bit) = even parity (XOR reduction) of m_data.
  - Computed at push time and stored per entry.
  - Reset value 0.
- Not defined: no m_parity port and no parity storage.

Decomposition:
- Shared package async_fifo_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_FINISH=2'd2;
  - default DATA_SIZE/ADDR_SIZE constants shared with async_fifo.
- One natural sub-module: stream_skid_buf, the 2-entry {data,last[,parity]} buffer with occ, push/pop.
- FSM and beat counter stay in the top level.

Test Plan:
- BURST_LEN=4, enable=1, FIFO preloaded 0x0..0x7, m_ready=1 -> 8 consecutive m_valid beats 0x0..0x7; m_last on 0x3 and 0x7; pkt_cnt=2.
- m_ready=0 for 10 cycles with FIFO holding 6 words -> exactly 2 pops (occ=2); m_data=0x0 held stable; rinc=0 until m_ready returns.
- enable dropped after 2nd pop of a packet (BURST_LEN=4) -> 2 more pops; m_last on 4th word; state IDLE; further FIFO data untouched.
- FIFO empties after 1 word of packet, refilled 50 cycles later -> rinc waits; packet completes with m_last on word 4; no spurious m_valid.
- rrst_n pulsed low with occ=2 mid-packet -> m_valid=0, pkt_cnt=0 immediately; after release with enable=1, next packet's last is on its 4th word.
- FIFO_RD_PARITY_EN defined: m_data=0x00000007 -> m_parity=1; m_data=0x00000003 -> m_parity=0.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared constants and types for async_fifo and its stream reader
//
// Purpose: read-side FSM state encoding and default widths shared with async_fifo.
// Ports  : none (package).
package async_fifo_pkg;

  localparam int DATA_SIZE_DEFAULT = 32;
  localparam int ADDR_SIZE_DEFAULT = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_RUN    = ST_RUN,
    S_FINISH = ST_FINISH
  } rd_state_t;

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - 2-entry in-order output buffer with occupancy count
//
// Purpose: holds up to two packed entries; entry 0 is the head presented downstream.
// Ports  : clk, rst_n     - clock, asynchronous active-low reset
//          push, push_data - write an entry (caller guarantees occ < 2)
//          pop            - remove the head (caller guarantees occ != 0)
//          head           - current head entry
//          occ            - number of valid entries, 0..2
module stream_skid_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic [1:0]   cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= push_data;
          else             e1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          // Keep the head value when draining the last entry so m_data
          // does not jump to stale slot-1 contents.
          if (cnt == 2'd2) e0 <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // Pushed word always lands behind the entry being popped.
          if (cnt == 2'd1) begin
            e0 <= push_data;
          end else begin
            e0 <= e1;
            e1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = e0;
  assign occ  = cnt;

endmodule

// File: rtl/async_fifo_stream_reader.sv
// rtl/async_fifo_stream_reader.sv - async_fifo read-side consumer producing fixed-length packets
//
// Purpose: pops words from an FWFT async_fifo read port and presents them as a
//          valid/ready stream, marking every BURST_LEN-th word with m_last.
//          Optional macro FIFO_RD_PARITY_EN adds m_parity (XOR of m_data).
// Ports  : rclk, rrst_n         - read clock, asynchronous active-low reset
//          enable               - allows new packets to start
//          rempty, rinc, rdata  - FIFO read port (rinc is the pop strobe)
//          m_valid, m_ready, m_data, m_last [, m_parity] - output stream
//          busy                 - FSM active or buffer non-empty
//          pkt_cnt              - completed packets, wraps
module async_fifo_stream_reader
  import async_fifo_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEFAULT,
  parameter int BURST_LEN = 16,
  parameter int CNT_SIZE  = 16
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 enable,
  input  logic                 rempty,
  output logic                 rinc,
  input  logic [DATA_SIZE-1:0] rdata,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_last,
`ifdef FIFO_RD_PARITY_EN
  output logic                 m_parity,
`endif
  output logic                 busy,
  output logic [CNT_SIZE-1:0]  pkt_cnt
);

  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
`ifdef FIFO_RD_PARITY_EN
  localparam int EW = DATA_SIZE + 2;
`else
  localparam int EW = DATA_SIZE + 1;
`endif

  rd_state_t         state;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] beat_nxt;
  logic [1:0]        occ;
  logic [EW-1:0]     head;
  logic [EW-1:0]     push_word;
  logic              push_last;
  logic              xfer;

  assign push_last = (beat == LAST_BEAT);
  assign rinc      = (state != S_IDLE) & ~rempty & (occ != 2'd2);
  assign xfer      = m_valid & m_ready;

`ifdef FIFO_RD_PARITY_EN
  assign push_word = {^rdata, push_last, rdata};
  assign m_parity  = head[DATA_SIZE+1];
`else
  assign push_word = {push_last, rdata};
`endif

  stream_skid_buf #(.W(EW)) u_buf (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .push      (rinc),
    .push_data (push_word),
    .pop       (xfer),
    .head      (head),
    .occ       (occ)
  );

  assign m_valid = (occ != 2'd0);
  assign m_data  = head[DATA_SIZE-1:0];
  assign m_last  = head[DATA_SIZE];
  assign busy    = (state != S_IDLE) | (occ != 2'd0);

  always_comb begin
    beat_nxt = beat;
    if (rinc) beat_nxt = push_last ? '0 : beat + BEAT_W'(1);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state   <= S_IDLE;
      beat    <= '0;
      pkt_cnt <= '0;
    end else begin
      beat <= beat_nxt;
      if (xfer && m_last) pkt_cnt <= pkt_cnt + CNT_SIZE'(1);
      case (state)
        S_IDLE:   if (enable) state <= S_RUN;
        // Decide on the post-pop beat: a pop this very cycle may open a
        // packet (must finish it) or close one (safe to go idle).
        S_RUN:    if (!enable) state <= (beat_nxt != '0) ? S_FINISH : S_IDLE;
        S_FINISH: if (rinc && push_last) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_async_fifo_stream_reader.sv
// tb/tb_async_fifo_stream_reader.sv - self-checking bench for async_fifo_stream_reader
module tb_async_fifo_stream_reader;

  localparam int BL = 4;
  localparam int CW = 3;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic          enable;
  logic          rempty;
  logic          rinc;
  logic [31:0]   rdata;
  logic          m_valid;
  logic          m_ready;
  logic [31:0]   m_data;
  logic          m_last;
  logic          busy;
  logic [CW-1:0] pkt_cnt;
`ifdef FIFO_RD_PARITY_EN
  logic          m_parity;
`endif

  async_fifo_stream_reader #(.DATA_SIZE(32), .BURST_LEN(BL), .CNT_SIZE(CW)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .enable  (enable),
    .rempty  (rempty),
    .rinc    (rinc),
    .rdata   (rdata),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
`ifdef FIFO_RD_PARITY_EN
    .m_parity(m_parity),
`endif
    .busy    (busy),
    .pkt_cnt (pkt_cnt)
  );

  always #5 rclk = ~rclk;

  localparam int M_IDLE = 0, M_RUN = 1, M_FIN = 2;

  typedef struct { logic [31:0] d; bit l; } ent_t;
  typedef struct {
    int add; bit en; bit rdy; int cycles;
    int exp_left; int exp_cnt; bit exp_busy;
  } phase_t;

  logic [31:0] fifo_q[$];
  ent_t        mbuf[$];
  int          mstate, mbeat, mcnt;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] next_word = 0;
  int          xfer_idx, first_last;
  phase_t      tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mstate = M_IDLE; mbeat = 0; mcnt = 0; mbuf.delete();
    xfer_idx = 0; first_last = 0;
  endtask

  task automatic add_words(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(rnd ? $urandom : next_word);
      next_word++;
    end
  endtask

  // One clock: drive FIFO view, check outputs against the model, advance the model.
  task automatic cycle();
    bit exp_rinc, exp_valid, xf;
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 32'hBAD0_BAD0 : fifo_q[0];
    #1;
    exp_rinc  = (mstate != M_IDLE) && (fifo_q.size() > 0) && (mbuf.size() < 2);
    exp_valid = (mbuf.size() > 0);
    chk("rinc", {31'd0, rinc}, {31'd0, exp_rinc});
    chk("m_valid", {31'd0, m_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      chk("m_data", m_data, mbuf[0].d);
      chk("m_last", {31'd0, m_last}, {31'd0, mbuf[0].l});
`ifdef FIFO_RD_PARITY_EN
      chk("m_parity", {31'd0, m_parity}, {31'd0, ^mbuf[0].d});
`endif
    end
    chk("busy", {31'd0, busy}, {31'd0, (mstate != M_IDLE) || exp_valid});
    chk("pkt_cnt", {29'd0, pkt_cnt}, 32'(mcnt % (1 << CW)));
    xf = exp_valid && m_ready;
    if (xf) begin
      xfer_idx++;
      if (mbuf[0].l) begin
        mcnt++;
        if (first_last == 0) first_last = xfer_idx;
      end
      void'(mbuf.pop_front());
    end
    if (exp_rinc) begin
      mbuf.push_back('{fifo_q[0], mbeat == BL - 1});
      mbeat = (mbeat + 1) % BL;
      void'(fifo_q.pop_front());
    end
    case (mstate)
      M_IDLE: if (enable) mstate = M_RUN;
      M_RUN:  if (!enable) mstate = (mbeat != 0) ? M_FIN : M_IDLE;
      default: if (exp_rinc && mbeat == 0) mstate = M_IDLE;
    endcase
    @(negedge rclk);
  endtask

  initial begin
    //            add en rdy cyc left cnt busy
    tbl[0] = '{8, 1, 1, 12, 0, 2, 1};  // two full packets back to back
    tbl[1] = '{6, 1, 0, 10, 4, 2, 1};  // stalled: only 2 pops
    tbl[2] = '{0, 1, 1, 10, 0, 3, 1};  // drain, ends mid-packet at beat 2
    tbl[3] = '{4, 0, 1, 10, 2, 4, 0};  // enable drop: finish packet only
    tbl[4] = '{0, 0, 1,  5, 2, 4, 0};  // idle leaves FIFO untouched
    tbl[5] = '{0, 1, 1,  6, 0, 4, 1};  // restart, FIFO runs dry mid-packet
    tbl[6] = '{0, 1, 1, 50, 0, 4, 1};  // long wait, no spurious output
    tbl[7] = '{2, 1, 1,  6, 0, 5, 1};  // refill completes packet

    rrst_n = 1'b0; enable = 1'b1; m_ready = 1'b1;
    rempty = 1'b0; rdata = 32'h1234_5678;
    model_reset();
    @(negedge rclk); @(negedge rclk);
    chk("rst_rinc", {31'd0, rinc}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_m_last", {31'd0, m_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pkt_cnt", {29'd0, pkt_cnt}, 32'd0);
    enable = 1'b0;
    rrst_n = 1'b1;
    @(negedge rclk);

    for (int p = 0; p < 8; p++) begin
      add_words(tbl[p].add, 1'b0);
      enable  = tbl[p].en;
      m_ready = tbl[p].rdy;
      for (int c = 0; c < tbl[p].cycles; c++) cycle();
      chk($sformatf("ph%0d_fifo_left", p), fifo_q.size(), tbl[p].exp_left);
      chk($sformatf("ph%0d_pkt_cnt", p), {29'd0, pkt_cnt}, tbl[p].exp_cnt);
      chk($sformatf("ph%0d_busy", p), {31'd0, busy}, {31'd0, tbl[p].exp_busy});
    end

    // Reset with a full buffer in the middle of a packet.
    add_words(6, 1'b0);
    enable = 1'b1; m_ready = 1'b0;
    for (int c = 0; c < 4; c++) cycle();
    chk("pre_rst_m_valid", {31'd0, m_valid}, 32'd1);
    rrst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_pkt_cnt", {29'd0, pkt_cnt}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_rinc", {31'd0, rinc}, 32'd0);
    fifo_q.delete();
    model_reset();
    @(negedge rclk);
    rrst_n = 1'b1;
    add_words(8, 1'b0);
    m_ready = 1'b1;
    for (int c = 0; c < 14; c++) cycle();
    chk("post_rst_first_last", first_last, 4);
    chk("post_rst_pkt_cnt", {29'd0, pkt_cnt}, 32'd2);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      m_ready = ($urandom_range(0, 3) != 0);
      if (fifo_q.size() < 12 && $urandom_range(0, 2) != 0) add_words(1, 1'b1);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
